// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a length-prefixed little-endian byte stream, writes 32-bit
// words from address 0 upward, and holds the core in reset until a load has completed.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  error
);

  // 17 bits so that a full 16-bit address space (65536 words) still compares correctly
  localparam logic [16:0] Depth = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    StIdle, StLenLo, StLenHi, StData, StWrite, StDone, StErr
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [15:0]           words_left_q, words_left_d;
  logic [15:0]           len_full;
  logic                  xfer;

  assign xfer     = in_valid & in_ready;
  assign len_full = {in_data, len_lo_q};

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    byte_cnt_d   = byte_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    words_left_d = words_left_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) state_d = StLenLo;
      end
      StLenLo: begin
        if (xfer) begin
          len_lo_d = in_data;
          state_d  = StLenHi;
        end
      end
      StLenHi: begin
        if (xfer) begin
          if (len_full == 16'd0) begin
            state_d = StDone;
          end else if ({1'b0, len_full} > Depth) begin
            state_d = StErr;
          end else begin
            state_d      = StData;
            byte_cnt_d   = 2'd0;
            addr_d       = '0;
            words_left_d = len_full;
          end
        end
      end
      StData: begin
        if (xfer) begin
          wdata_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = StWrite;
        end
      end
      StWrite: begin
        // The increment after the last word of a DEPTH-long load wraps to 0 harmlessly
        addr_d       = addr_q + 1'b1;
        words_left_d = words_left_q - 16'd1;
        state_d      = (words_left_q == 16'd1) ? StDone : StData;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      len_lo_q     <= 8'd0;
      byte_cnt_q   <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      words_left_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      byte_cnt_q   <= byte_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      words_left_q <= words_left_d;
    end
  end

  assign in_ready  = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StData);
  assign mem_we    = (state_q == StWrite);
  assign cpu_rst   = (state_q != StDone);
  assign done      = (state_q == StDone);
  assign error     = (state_q == StErr);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader with a scoreboard of expected memory writes.
module tb_imem_loader;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk, rst, start, in_valid;
  logic [7:0]    in_data;
  logic          in_ready, mem_we, cpu_rst, done, error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_fail = 0;
  int  n_we = 0;
  int  cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write
  always @(negedge clk) begin : monitor
    wr_t e;
    if (!rst && mem_we) begin
      n_we++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write",
                 mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.a));
        check("wr_data", mem_wdata, e.d);
      end
    end
  end

  task automatic drive(input logic [7:0] q[$], input int gap_pct, input bit noise);
    int idx = 0;
    int guard = 0;
    while (idx < q.size() && guard < 2000) begin
      @(negedge clk);
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = in_valid ? q[idx] : 8'($urandom);
      start    = noise ? 1'($urandom) : 1'b0;
      if (in_valid && in_ready) idx++;
      guard++;
    end
    check("drive_bytes_accepted", idx, q.size());
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Builds the stream and expected writes for one load of `len` words, from word list or random
  task automatic build(input logic [15:0] len, input logic [31:0] words[$], input int max_words,
                       output logic [7:0] q[$]);
    logic [31:0] w;
    q = {};
    q.push_back(len[7:0]);
    q.push_back(len[15:8]);
    if (len != 0 && int'(len) <= DEPTH) begin
      for (int i = 0; i < int'(len); i++) begin
        w = (i < words.size()) ? words[i] : $urandom;
        if (i < max_words) exp_q.push_back('{a: AW'(i), d: w});
        for (int b = 0; b < 4; b++) q.push_back(w[8*b +: 8]);
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_cpu_rst", cpu_rst, 1'b1);
    check("start_done", done, 1'b0);
    check("start_in_ready", in_ready, 1'b1);
  endtask

  task automatic do_load(input logic [15:0] len, input logic [31:0] words[$], input int gap,
                         input bit noise, input int exp_cycles);
    logic [7:0] q[$];
    int  t0, w0, guard;
    bit  exp_err, legal;
    exp_err = (int'(len) > DEPTH);
    legal   = (len != 0) && !exp_err;
    build(len, words, 1 << 20, q);
    w0 = n_we;
    pulse_start();
    t0 = cyc;
    drive(q, gap, noise);
    guard = 0;
    while (!(done || error) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("complete_in_bound", guard < 500, 1);
    if (exp_cycles > 0) check("latency", cyc - t0, exp_cycles);
    check("done", done, !exp_err);
    check("error", error, exp_err);
    check("cpu_rst", cpu_rst, exp_err);
    check("in_ready_end", in_ready, 1'b0);
    check("we_count", n_we - w0, legal ? int'(len) : 0);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [31:0] two[$];
    logic [31:0] none[$];
    logic [7:0]  q[$];
    logic [15:0] l;
    two  = {32'h00A00513, 32'h00100593};
    none = {};
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    #3;
    check("rst_cpu_rst", cpu_rst, 1'b1);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk);
    rst = 1'b0;

    do_load(16'd2, two, 0, 1'b0, 12);   // 10 transfers + 2 WRITE cycles
    do_load(16'd2, two, 40, 1'b0, 0);
    do_load(16'd5, none, 0, 1'b0, 0);
    do_load(16'd4, none, 20, 1'b0, 0);
    do_load(16'd0, none, 0, 1'b0, 0);

    // Reset after 6 data bytes: only the first word may reach memory
    build(16'd3, none, 1, q);
    while (q.size() > 8) void'(q.pop_back());
    n_we = 0;
    pulse_start();
    drive(q, 30, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_cpu_rst", cpu_rst, 1'b1);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_mem_we", mem_we, 1'b0);
    check("midrst_writes", n_we, 1);
    check("midrst_queue", exp_q.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    do_load(16'd3, none, 10, 1'b0, 0);

    // Reload from DONE with stray start pulses during DATA
    do_load(16'd2, none, 25, 1'b1, 0);

    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(3))
        0:       l = 16'h0100 + 16'($urandom_range(4));
        1:       l = 16'hFFFF;
        default: l = 16'($urandom_range(6));
      endcase
      do_load(l, none, $urandom_range(50), 1'($urandom), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
